// File: rtl/vga_frame_ram.sv
// Dual-port frame buffer: CPU read/write port A, scrolled scan-out port B, and a whole-buffer fill engine.
// Reads are registered (1 cycle); port B never stalls, while port A writes are dropped during a fill (busy=1).
module vga_frame_ram #(
  parameter int    DATA_W      = 32,
  parameter int    DEPTH       = 2048,
  parameter int    ADDR_W      = 11,
  parameter bit    WRITE_FIRST = 1'b0,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_en,
  input  logic [DATA_W/8-1:0] a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [ADDR_W-1:0] b_base,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              fill_done,
  output logic              update
);
  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] fill_q;
  logic              a_wr;
  logic              a_upd_q;
  logic [NB-1:0]     w_be;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] a_old;
  logic [DATA_W-1:0] a_merged;
  logic [DATA_W-1:0] a_rd_nxt;
  logic [ADDR_W-1:0] b_phys;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fill_start) state_nxt = FILL;
      FILL:    if (cnt == ADDR_W'(DEPTH - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == FILL);
    fill_done = (state == DONE);
    update    = a_upd_q | fill_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      fill_q <= '0;
    end else if (state == IDLE && fill_start) begin
      cnt    <= '0;
      fill_q <= fill_value;
    end else if (state == FILL) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fill and port A writes are mutually exclusive (busy gates port A), so one write port suffices.
  always_comb begin
    a_wr   = a_en && !busy && !rst;
    w_be   = '0;
    w_addr = a_addr;
    w_data = a_wdata;
    if (state == FILL && !rst) begin
      w_be   = '1;
      w_addr = cnt;
      w_data = fill_q;
    end else if (a_wr) begin
      w_be = a_we;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NB; k++)
      if (w_be[NB-1-k]) mem[w_addr][8*k +: 8] <= w_data[8*k +: 8];
  end

  assign a_old  = mem[a_addr];
  assign b_phys = b_addr + b_base;

  // a_we bit 0 selects the most significant byte.
  always_comb begin
    a_merged = a_old;
    for (int k = 0; k < NB; k++)
      if (a_we[NB-1-k]) a_merged[8*k +: 8] = a_wdata[8*k +: 8];
    a_rd_nxt = (WRITE_FIRST && a_wr) ? a_merged : a_old;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
      a_upd_q <= 1'b0;
    end else begin
      if (a_en) a_rdata <= a_rd_nxt;
      b_rdata <= mem[b_phys];
      a_upd_q <= a_wr && (a_we != '0);
    end
  end
endmodule

// File: tb/tb_vga_frame_ram.sv
// Bench for vga_frame_ram: read-first and write-first instances share stimulus; a word-array model predicts outputs.
module tb_vga_frame_ram;
  logic        clk = 1'b0;
  logic        rst, a_en, fill_start;
  logic [3:0]  a_we;
  logic [10:0] a_addr, b_addr, b_base;
  logic [31:0] a_wdata, fill_value;
  logic [31:0] a_rdata0, b_rdata0, a_rdata1, b_rdata1;
  logic        busy0, fill_done0, update0, busy1, fill_done1, update1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_frame_ram #(.WRITE_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata0), .b_addr(b_addr), .b_base(b_base), .b_rdata(b_rdata0),
    .fill_start(fill_start), .fill_value(fill_value), .busy(busy0), .fill_done(fill_done0),
    .update(update0));

  vga_frame_ram #(.WRITE_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata1), .b_addr(b_addr), .b_base(b_base), .b_rdata(b_rdata1),
    .fill_start(fill_start), .fill_value(fill_value), .busy(busy1), .fill_done(fill_done1),
    .update(update1));

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic        chk0;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic        upd;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] ref_mem [2048];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Byte k (bits 8k+7:8k) is enabled by we[3-k].
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++)
      if (we[3-k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  initial begin
    int nbusy, upd_during, guard, nerr, nd;
    logic [31:0] e0, e1, eb, fv;
    logic        eu;
    logic [10:0] tgt;

    vecs[0] = '{1'b1, 4'hF, 11'd5, 32'hDEADBEEF, 1'b0, 32'h0,        32'hDEADBEEF, 1'b1};
    vecs[1] = '{1'b1, 4'h0, 11'd5, 32'h0,        1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 4'h8, 11'd5, 32'h000000AA, 1'b1, 32'hDEADBEEF, 32'hDEADBEAA, 1'b1};
    vecs[3] = '{1'b0, 4'hF, 11'd5, 32'h12345678, 1'b1, 32'hDEADBEEF, 32'hDEADBEAA, 1'b0};
    vecs[4] = '{1'b1, 4'h0, 11'd5, 32'h0,        1'b1, 32'hDEADBEAA, 32'hDEADBEAA, 1'b0};
    vecs[5] = '{1'b1, 4'h1, 11'd5, 32'h77000000, 1'b1, 32'hDEADBEAA, 32'h77ADBEAA, 1'b1};
    vecs[6] = '{1'b1, 4'hF, 11'd3, 32'h11111111, 1'b0, 32'h0,        32'h11111111, 1'b1};
    vecs[7] = '{1'b1, 4'hF, 11'd4, 32'h22222222, 1'b0, 32'h0,        32'h22222222, 1'b1};
    vecs[8] = '{1'b1, 4'h0, 11'd5, 32'h0,        1'b1, 32'h77ADBEAA, 32'h77ADBEAA, 1'b0};

    rst = 1'b1; a_en = 1'b0; a_we = '0; a_addr = '0; a_wdata = '0;
    b_addr = '0; b_base = '0; fill_start = 1'b0; fill_value = '0;
    step(); step();
    check("reset_a_rdata", a_rdata0, 32'h0);
    check("reset_b_rdata", b_rdata0, 32'h0);
    check("reset_busy", busy0, 0);
    check("reset_fill_done", fill_done0, 0);
    check("reset_update", update0, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      a_en = vecs[i].en; a_we = vecs[i].we; a_addr = vecs[i].addr; a_wdata = vecs[i].wdata;
      step();
      if (vecs[i].chk0) check($sformatf("vec%0d_rdata_rf", i), a_rdata0, vecs[i].exp0);
      check($sformatf("vec%0d_rdata_wf", i), a_rdata1, vecs[i].exp1);
      check($sformatf("vec%0d_update", i), update0, vecs[i].upd);
    end
    a_en = 1'b0; a_we = '0;
    step();
    check("update_idle", update0, 0);

    b_base = 11'd2045; b_addr = 11'd6;
    step();
    check("scroll_wrap", b_rdata0, 32'h11111111);
    b_base = 11'd0; b_addr = 11'd4;
    step();
    check("scroll_zero", b_rdata0, 32'h22222222);

    // Full fill; port A write in the accept cycle is performed normally.
    fv = 32'h00200020;
    fill_start = 1'b1; fill_value = fv;
    a_en = 1'b1; a_we = 4'hF; a_addr = 11'd9; a_wdata = 32'h55555555;
    step();
    check("fill_accept_busy", busy0, 1);
    check("fill_accept_update", update0, 1);
    nbusy = 0; upd_during = 0; guard = 0;
    while (busy0 && guard < 3000) begin
      nbusy++; guard++;
      if (nbusy > 1 && update0) upd_during++;
      if (nbusy == 20) begin
        a_en = 1'b1; a_we = 4'hF; a_addr = 11'd7; a_wdata = 32'hBADBAD00;
      end else a_en = 1'b0;
      if (nbusy == 60) fill_start = 1'b0;
      step();
    end
    check("fill_busy_cycles", nbusy, 2048);
    check("fill_no_update_while_busy", upd_during, 0);
    check("fill_done_pulse", fill_done0, 1);
    check("fill_done_update", update0, 1);
    check("fill_done_busy_low", busy0, 0);
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (fill_done0 || busy0) nd++;
    end
    check("fill_single_done", nd, 0);

    for (int i = 0; i < 2048; i++) ref_mem[i] = fv;
    nerr = 0;
    a_en = 1'b1; a_we = '0; b_base = 11'd0;
    for (int i = 0; i < 2048; i++) begin
      a_addr = 11'(i); b_addr = 11'(i);
      step();
      if (a_rdata0 !== ref_mem[i] || b_rdata0 !== ref_mem[i] || a_rdata1 !== ref_mem[i]) nerr++;
    end
    check("fill_readback_errors", nerr, 0);
    a_addr = 11'd7;
    step();
    check("fill_discarded_write_addr7", a_rdata0, 32'h00200020);

    // Randomized traffic against the word-array model; both ports aimed at a small window.
    e0 = fv; e1 = fv;
    for (int it = 0; it < 400; it++) begin
      a_en    = ($urandom_range(0, 3) != 0);
      a_we    = 4'($urandom);
      a_addr  = 11'($urandom_range(0, 15));
      a_wdata = $urandom;
      tgt     = 11'($urandom_range(0, 15));
      b_base  = 11'($urandom);
      b_addr  = tgt - b_base;
      if (a_en) begin
        e0 = ref_mem[a_addr];
        e1 = merge(ref_mem[a_addr], a_wdata, a_we);
      end
      eb = ref_mem[tgt];
      eu = a_en && (a_we != 0);
      step();
      check("rand_a_rdata_rf", a_rdata0, e0);
      check("rand_a_rdata_wf", a_rdata1, e1);
      check("rand_b_rdata", b_rdata0, eb);
      check("rand_update", update0, eu);
      if (a_en) ref_mem[a_addr] = merge(ref_mem[a_addr], a_wdata, a_we);
    end

    // Abort a fill with rst after addresses 0..99 are written.
    a_en = 1'b0; a_we = '0;
    fill_start = 1'b1; fill_value = 32'hCAFEF00D;
    step();
    fill_start = 1'b0;
    for (int i = 0; i < 100; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", busy0, 0);
    check("abort_fill_done", fill_done0, 0);
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (fill_done0 || busy0 || update0) nd++;
    end
    check("abort_quiet", nd, 0);
    a_en = 1'b1; a_addr = 11'd99;
    step();
    check("abort_addr99", a_rdata0, 32'hCAFEF00D);
    a_addr = 11'd200;
    step();
    check("abort_addr200", a_rdata0, ref_mem[200]);
    a_en = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
